// File: rtl/instr_sequencer.sv
// instr_sequencer: program memory fetch and bit-serial instruction sequencer
module instr_sequencer #(
  parameter int AW = 4,
  parameter int NBITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     prog_we,
  input  logic [AW-1:0]            prog_addr,
  input  logic [3:0]               prog_data,
  input  logic                     start,
  input  logic                     step_mode,
  input  logic                     halt_req,
  input  logic [AW-1:0]            last_addr,
  output logic [3:0]               instr,
  output logic [AW-1:0]            pc,
  output logic [$clog2(NBITS)-1:0] bit_idx,
  output logic                     exec_en,
  output logic                     first_bit,
  output logic                     last_bit,
  output logic                     busy,
  output logic                     done
);
  localparam int BW = $clog2(NBITS);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
  state_t state, state_n;
  logic [3:0] mem [2**AW];
  logic step_r, halt_r, stop;
  assign exec_en = state == EXEC;
  assign busy = state != IDLE;
  assign first_bit = exec_en && bit_idx == '0;
  assign last_bit = exec_en && bit_idx == BW'(NBITS - 1);
  assign stop = last_bit && (pc == last_addr || halt_r || halt_req || step_r);
  always_comb begin
    state_n = state;
    state_n = state == IDLE  ? (start ? FETCH : IDLE) :
              state == FETCH ? EXEC :
              last_bit       ? (stop ? IDLE : FETCH) : EXEC;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (state == IDLE && prog_we) mem[prog_addr] <= prog_data;
  always_ff @(posedge clk)
    if (reset) begin
      pc <= '0;
      instr <= '0;
      bit_idx <= '0;
      step_r <= 1'b0;
      halt_r <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= stop;
      if (state == IDLE && start) begin
        step_r <= step_mode;
        halt_r <= 1'b0;
      end
      if (state != IDLE) halt_r <= halt_r | halt_req;
      if (state == FETCH) begin
        instr <= mem[pc];
        bit_idx <= '0;
      end
      if (exec_en) bit_idx <= bit_idx + 1'b1;
      if (last_bit) pc <= pc == last_addr ? '0 : pc + 1'b1;
    end
endmodule
